// File: rtl/cache_axi_bridge_if.sv
// cache_axi_bridge_if
//   AXI4 read/write channel bundle between the cache refill/writeback bridge
//   and the interconnect. The crossbar wrapper ties the fixed burst attributes
//   (ID=0, LEN=3, SIZE=2, BURST=INCR, WSTRB=4'hF), so they are not carried here.
//   master modport : bridge side (drives AR/AW/W valid+payload, R/B ready)
//   slave modport  : memory/interconnect side
interface cache_axi_bridge_if;
  // AR channel
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  // R channel
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AW channel
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  // W channel
  logic [31:0] wdata;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // B channel
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, input arready,
    input  rdata, rlast, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wlast, wvalid, input wready,
    input  bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rlast, rvalid, input rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wlast, wvalid, output wready,
    output bvalid, input bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//   Turns 16-byte cache line refills and dirty-line writebacks into 4-beat
//   32-bit AXI INCR bursts. Read and write engines run independently; a refill
//   that hits the line currently being written back waits until the writeback
//   has been acknowledged.
//   Ports:
//     clk, rst                 : clock (rising edge), async active-high reset
//     rd_req/rd_addr/rd_rdy    : refill request handshake
//     ret_valid/ret_data       : one-cycle refill completion, line held after
//     wr_req/wr_addr/wr_data/wr_rdy : writeback request handshake
//     wr_valid                 : one-cycle writeback acknowledge (B received)
//     axi                      : AXI channel bundle, master side
module cache_axi_bridge (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_req,
  input  logic [31:0]              rd_addr,
  output logic                     rd_rdy,
  output logic                     ret_valid,
  output logic [127:0]             ret_data,
  input  logic                     wr_req,
  input  logic [31:0]              wr_addr,
  input  logic [127:0]             wr_data,
  output logic                     wr_rdy,
  output logic                     wr_valid,
  cache_axi_bridge_if.master       axi
);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} w_state_t;

  r_state_t     r_state_q, r_state_d;
  logic [1:0]   rd_cnt_q, rd_cnt_d;
  logic [31:0]  araddr_q, araddr_d;
  logic [127:0] rbuf_q, rbuf_d;
  logic [127:0] ret_data_q, ret_data_d;

  w_state_t     w_state_q, w_state_d;
  logic [1:0]   wr_cnt_q, wr_cnt_d;
  logic [31:0]  awaddr_q, awaddr_d;
  logic [127:0] wline_q, wline_d;

  logic         wr_accept;
  logic         rd_accept;
  logic         hazard;
  logic [31:0]  wword [4];

  // Split the captured writeback line into beat-sized words.
  for (genvar gi = 0; gi < 4; gi++) begin : g_wword
    assign wword[gi] = wline_q[32*gi +: 32];
  end

  assign wr_rdy    = (w_state_q == W_IDLE) & ~rst;
  assign wr_accept = wr_req & wr_rdy;

  // A refill of the line being (or about to be) written back must observe the
  // written data, so it is held off until the writeback completes.
  assign hazard = ((w_state_q != W_IDLE) && (rd_addr[31:4] == awaddr_q[31:4])) ||
                  (wr_accept && (rd_addr[31:4] == wr_addr[31:4]));

  assign rd_rdy    = (r_state_q == R_IDLE) & ~hazard & ~rst;
  assign rd_accept = rd_req & rd_rdy;

  // Cache-side and AXI outputs decoded from registered state.
  assign ret_valid   = (r_state_q == R_DONE);
  assign ret_data    = ret_data_q;
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = (r_state_q == R_AR);
  assign axi.rready  = (r_state_q == R_DATA);

  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = (w_state_q == W_AW);
  assign axi.wvalid  = (w_state_q == W_DATA);
  assign axi.wdata   = (w_state_q == W_DATA) ? wword[wr_cnt_q] : 32'h0;
  assign axi.wlast   = (w_state_q == W_DATA) && (wr_cnt_q == 2'd3);
  assign axi.bready  = (w_state_q == W_RESP);
  // Acknowledge in the B handshake cycle so the next request lands one cycle later.
  assign wr_valid    = (w_state_q == W_RESP) & axi.bvalid;

  // Read engine
  always_comb begin
    r_state_d  = r_state_q;
    rd_cnt_d   = rd_cnt_q;
    araddr_d   = araddr_q;
    rbuf_d     = rbuf_q;
    ret_data_d = ret_data_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (rd_accept) begin
          araddr_d  = {rd_addr[31:4], 4'b0};
          rd_cnt_d  = 2'd0;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        if (axi.arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        // Beat count alone ends the burst; an early rlast is not trusted.
        if (axi.rvalid) begin
          rbuf_d[{rd_cnt_q, 5'b0} +: 32] = axi.rdata;
          rd_cnt_d = rd_cnt_q + 2'd1;
          if (rd_cnt_q == 2'd3) begin
            // Publish the whole line at once so ret_data is stable between refills.
            ret_data_d = {axi.rdata, rbuf_q[95:0]};
            r_state_d  = R_DONE;
          end
        end
      end
      R_DONE: r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write engine
  always_comb begin
    w_state_d = w_state_q;
    wr_cnt_d  = wr_cnt_q;
    awaddr_d  = awaddr_q;
    wline_d   = wline_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (wr_accept) begin
          awaddr_d  = {wr_addr[31:4], 4'b0};
          wline_d   = wr_data;
          wr_cnt_d  = 2'd0;
          w_state_d = W_AW;
        end
      end
      W_AW: begin
        if (axi.awready) w_state_d = W_DATA;
      end
      W_DATA: begin
        if (axi.wready) begin
          wr_cnt_d = wr_cnt_q + 2'd1;
          if (wr_cnt_q == 2'd3) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi.bvalid) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q  <= R_IDLE;
      rd_cnt_q   <= 2'd0;
      araddr_q   <= 32'h0;
      rbuf_q     <= 128'h0;
      ret_data_q <= 128'h0;
      w_state_q  <= W_IDLE;
      wr_cnt_q   <= 2'd0;
      awaddr_q   <= 32'h0;
      wline_q    <= 128'h0;
    end else begin
      r_state_q  <= r_state_d;
      rd_cnt_q   <= rd_cnt_d;
      araddr_q   <= araddr_d;
      rbuf_q     <= rbuf_d;
      ret_data_q <= ret_data_d;
      w_state_q  <= w_state_d;
      wr_cnt_q   <= wr_cnt_d;
      awaddr_q   <= awaddr_d;
      wline_q    <= wline_d;
    end
  end

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge
//   Directed bench for cache_axi_bridge: reset state, refill, writeback with
//   stalled W channel, same-line hazard, independent concurrent transfers,
//   reset mid-refill and an early rlast.
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         wr_valid;

  cache_axi_bridge_if bus ();

  cache_axi_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_rdy    (rd_rdy),
    .ret_valid (ret_valid),
    .ret_data  (ret_data),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_rdy    (wr_rdy),
    .wr_valid  (wr_valid),
    .axi       (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] LINE_A = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] LINE_W = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LINE_B = 128'h0B0B0B0B_0A0A0A0A_09090909_08080808;
  localparam logic [127:0] LINE_C = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_D = 128'h00000008_00000007_00000006_00000005;
  localparam logic [127:0] LINE_E = 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0;

  int n_cmp = 0;
  int n_bad = 0;
  int ret_pulses = 0;
  int wr_pulses = 0;
  int hz_viol = 0;
  logic hz_watch = 1'b0;

  always @(negedge clk) begin
    if (ret_valid === 1'b1) ret_pulses++;
    if (wr_valid === 1'b1) wr_pulses++;
    if (hz_watch && rd_rdy !== 1'b0) hz_viol++;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_issue(input logic [31:0] addr, input string tag);
    int n;
    rd_req  = 1'b1;
    rd_addr = addr;
    #1;
    n = 0;
    while (rd_rdy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_val({tag, "_rd_rdy"}, rd_rdy, 1);
    step();
    rd_req = 1'b0;
  endtask

  // Starts right after the refill was accepted; AR is granted one cycle late.
  task automatic rd_finish(input logic [31:0] exp_addr, input logic [127:0] line,
                           input int last_beat, input string tag);
    int p0;
    p0 = ret_pulses;
    check_val({tag, "_arvalid"}, bus.arvalid, 1);
    check_val({tag, "_araddr"}, bus.araddr, exp_addr);
    step();
    check_val({tag, "_ar_hold"}, bus.arvalid, 1);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    check_val({tag, "_rready"}, bus.rready, 1);
    check_val({tag, "_ar_drop"}, bus.arvalid, 0);
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = line[32*i +: 32];
      bus.rlast  = (i == last_beat);
      step();
      if (i < 3) check_val({tag, "_no_early_ret"}, ret_valid, 0);
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    check_val({tag, "_ret_valid"}, ret_valid, 1);
    check_val({tag, "_ret_data"}, ret_data, line);
    step();
    check_val({tag, "_ret_pulse_end"}, ret_valid, 0);
    check_val({tag, "_ret_data_hold"}, ret_data, line);
    check_val({tag, "_ret_count"}, ret_pulses - p0, 1);
  endtask

  task automatic wr_issue(input logic [31:0] addr, input logic [127:0] line, input string tag);
    int n;
    wr_req  = 1'b1;
    wr_addr = addr;
    wr_data = line;
    #1;
    n = 0;
    while (wr_rdy !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_val({tag, "_wr_rdy"}, wr_rdy, 1);
    step();
    wr_req = 1'b0;
  endtask

  // Starts right after the writeback was accepted. toggle=1 inserts a
  // wready-low cycle after each accepted beat.
  task automatic wr_finish(input logic [31:0] exp_addr, input logic [127:0] line,
                           input bit toggle, input string tag);
    int p0;
    p0 = wr_pulses;
    check_val({tag, "_awvalid"}, bus.awvalid, 1);
    check_val({tag, "_awaddr"}, bus.awaddr, exp_addr);
    bus.awready = 1'b1;
    step();
    bus.awready = 1'b0;
    check_val({tag, "_aw_drop"}, bus.awvalid, 0);
    check_val({tag, "_wvalid"}, bus.wvalid, 1);
    for (int i = 0; i < 4; i++) begin
      bus.wready = 1'b1;
      check_val($sformatf("%s_wdata%0d", tag, i), bus.wdata, line[32*i +: 32]);
      check_val($sformatf("%s_wlast%0d", tag, i), bus.wlast, (i == 3));
      step();
      bus.wready = 1'b0;
      if (toggle && i < 3) begin
        check_val($sformatf("%s_wvalid_hold%0d", tag, i), bus.wvalid, 1);
        check_val($sformatf("%s_wdata_next%0d", tag, i), bus.wdata, line[32*(i+1) +: 32]);
        step();
      end
    end
    check_val({tag, "_w_done"}, bus.wvalid, 0);
    check_val({tag, "_bready"}, bus.bready, 1);
    check_val({tag, "_no_early_ack"}, wr_valid, 0);
    bus.bvalid = 1'b1;
    #1;
    check_val({tag, "_wr_valid"}, wr_valid, 1);
    step();
    bus.bvalid = 1'b0;
    check_val({tag, "_wr_valid_end"}, wr_valid, 0);
    check_val({tag, "_wr_rdy_back"}, wr_rdy, 1);
    check_val({tag, "_wr_count"}, wr_pulses - p0, 1);
  endtask

  initial begin
    int p_before;
    rst = 1'b1;
    rd_req = 1'b0; rd_addr = 32'h0;
    wr_req = 1'b0; wr_addr = 32'h0; wr_data = 128'h0;
    bus.arready = 1'b0;
    bus.rdata = 32'h0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;

    // Reset state, with requests pending to show they are not accepted
    step();
    step();
    rd_req = 1'b1;
    wr_req = 1'b1;
    #1;
    check_val("rst_rd_rdy", rd_rdy, 0);
    check_val("rst_wr_rdy", wr_rdy, 0);
    check_val("rst_arvalid", bus.arvalid, 0);
    check_val("rst_awvalid", bus.awvalid, 0);
    check_val("rst_rready", bus.rready, 0);
    check_val("rst_wvalid", bus.wvalid, 0);
    check_val("rst_bready", bus.bready, 0);
    check_val("rst_ret_valid", ret_valid, 0);
    check_val("rst_ret_data", ret_data, 128'h0);
    check_val("rst_araddr", bus.araddr, 0);
    check_val("rst_wdata", bus.wdata, 0);
    rd_req = 1'b0;
    wr_req = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check_val("post_rst_rd_rdy", rd_rdy, 1);
    check_val("post_rst_wr_rdy", wr_rdy, 1);
    step();

    // Refill: line-aligned address, late arready, ordered words
    rd_issue(32'h1FC0_0014, "refill");
    rd_finish(32'h1FC0_0010, LINE_A, 3, "refill");

    // Writeback with W channel stalling every other cycle
    wr_issue(32'h8000_0020, LINE_W, "wb");
    wr_finish(32'h8000_0020, LINE_W, 1'b1, "wb");
    step();

    // Same-line hazard: write goes first, refill waits for the acknowledge
    rd_req  = 1'b1; rd_addr = 32'h8000_004C;
    wr_req  = 1'b1; wr_addr = 32'h8000_0040; wr_data = LINE_C;
    #1;
    check_val("haz_wr_rdy", wr_rdy, 1);
    check_val("haz_rd_rdy", rd_rdy, 0);
    step();
    wr_req = 1'b0;
    hz_watch = 1'b1;
    wr_finish(32'h8000_0040, LINE_C, 1'b0, "haz_wb");
    hz_watch = 1'b0;
    check_val("haz_rd_held_count", hz_viol, 0);
    check_val("haz_rd_rdy_release", rd_rdy, 1);
    check_val("haz_no_ar_yet", bus.arvalid, 0);
    step();
    rd_req = 1'b0;
    rd_finish(32'h8000_0040, LINE_B, 3, "haz_rd");

    // Different lines: both accepted together, AR and AW next cycle
    rd_req  = 1'b1; rd_addr = 32'h8000_0080;
    wr_req  = 1'b1; wr_addr = 32'h8000_0040; wr_data = LINE_E;
    #1;
    check_val("dual_rd_rdy", rd_rdy, 1);
    check_val("dual_wr_rdy", wr_rdy, 1);
    step();
    rd_req = 1'b0;
    wr_req = 1'b0;
    check_val("dual_arvalid", bus.arvalid, 1);
    check_val("dual_awvalid", bus.awvalid, 1);
    rd_finish(32'h8000_0080, LINE_D, 3, "dual_rd");
    wr_finish(32'h8000_0040, LINE_E, 1'b0, "dual_wb");
    step();

    // Reset after the second R beat abandons the refill silently
    rd_issue(32'h0000_1238, "rst_mid");
    check_val("rst_mid_arvalid", bus.arvalid, 1);
    bus.arready = 1'b1;
    step();
    bus.arready = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 32'h0000_00E1;
    step();
    bus.rdata = 32'h0000_00E2;
    step();
    bus.rvalid = 1'b0;
    p_before = ret_pulses;
    rst = 1'b1;
    #1;
    check_val("rst_mid_rready", bus.rready, 0);
    check_val("rst_mid_arvalid_low", bus.arvalid, 0);
    check_val("rst_mid_rd_rdy", rd_rdy, 0);
    check_val("rst_mid_ret_data", ret_data, 128'h0);
    step();
    step();
    rst = 1'b0;
    check_val("rst_mid_no_ret", ret_pulses - p_before, 0);
    rd_issue(32'h0000_1230, "after_rst");
    rd_finish(32'h0000_1230, LINE_D, 3, "after_rst");

    // Early rlast on beat 2 is ignored; completion follows the 4th beat
    rd_issue(32'h0000_2004, "early_rlast");
    rd_finish(32'h0000_2000, LINE_B, 1, "early_rlast");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 Block SHALL have no parameters: 16-byte line, 4 x 32-bit INCR beats; crossbar wrapper ties ID=0, LEN=3, SIZE=2, BURST=INCR, WSTRB=4'hF.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  async active-high reset.
REQ-005 rd_req  in  1  cache line-refill request.
REQ-006 rd_addr  in  32  refill address, any byte in line.
REQ-007 rd_rdy  out  1  refill request accepted when high with rd_req.
REQ-008 ret_valid  out  1  one-cycle pulse: ret_data holds full line.
REQ-009 ret_data  out  128  refilled line, word k at bits [32k+31:32k].
REQ-010 wr_req  in  1  dirty-line writeback request.
REQ-011 wr_addr  in  32  writeback address.
REQ-012 wr_data  in  128  writeback line, same word packing as ret_data.
REQ-013 wr_rdy  out  1  writeback request accepted when high with wr_req.
REQ-014 wr_valid  out  1  one-cycle pulse: writeback acknowledged by B channel.
REQ-015 araddr  out  32  AR address.
REQ-016 arvalid  out  1  AR valid.
REQ-017 arready  in  1  AR ready.
REQ-018 rdata  in  32  R data beat.
REQ-019 rlast  in  1  R last beat.
REQ-020 rvalid  in  1  R valid.
REQ-021 rready  out  1  R ready.
REQ-022 awaddr  out  32  AW address.
REQ-023 awvalid  out  1  AW valid.
REQ-024 awready  in  1  AW ready.
REQ-025 wdata  out  32  W data beat.
REQ-026 wlast  out  1  W last beat.
REQ-027 wvalid  out  1  W valid.
REQ-028 wready  in  1  W ready.
REQ-029 bvalid  in  1  B valid.
REQ-030 bready  out  1  B ready.

Function
REQ-031 Read FSM SHALL use states R_IDLE, R_AR, R_DATA, R_DONE; rd_rdy = (state==R_IDLE) & ~hazard & ~rst.
REQ-032 On rd_req&rd_rdy: latch {rd_addr[31:4],4'b0} into araddr, clear 2-bit beat counter, go R_AR; arvalid=1 only in R_AR; arvalid&arready -> R_DATA.
REQ-033 R_DATA: rready=1; each rvalid stores rdata into word[counter], counter+1; beat with counter==3 -> R_DONE regardless of rlast; rlast on an earlier beat SHALL be ignored.
REQ-034 R_DONE: ret_valid=1 for exactly one cycle, then R_IDLE; ret_data SHALL hold its value until the next R_DONE.
REQ-035 Write FSM SHALL use states W_IDLE, W_AW, W_DATA, W_RESP; wr_rdy = (state==W_IDLE) & ~rst.
REQ-036 On wr_req&wr_rdy: latch line-aligned address and 128-bit data, go W_AW; awvalid=1 only in W_AW; awvalid&awready -> W_DATA.
REQ-037 W_DATA: wvalid=1, wdata=word[counter], wlast=(counter==3); counter advances only on wvalid&wready; last accepted beat -> W_RESP.
REQ-038 W_RESP: bready=1; bvalid -> wr_valid pulse one cycle, W_IDLE; BRESP ignored.
REQ-039 Read and write FSMs SHALL run concurrently; both requests may be accepted in the same cycle.
REQ-040 Hazard: hazard=1 when write FSM not idle (or wr_req accepted this cycle) and rd_addr[31:4] equals pending/incoming write line; refill then held off until write FSM returns to W_IDLE.
REQ-041 Back-to-back: new request accepted at earliest the cycle after ret_valid/wr_valid pulse (idle cycle).
REQ-042 AXI outputs SHALL be registered or decoded from registered state only; valid SHALL not drop before the matching ready.

Reset
REQ-043 While rst high: both FSMs idle, counters 0, arvalid/rready/awvalid/wvalid/wlast/bready/ret_valid/wr_valid=0, rd_rdy/wr_rdy=0, ret_data=0, araddr/awaddr/wdata=0.
REQ-044 Reset mid-transaction SHALL abandon it silently: no ret_valid/wr_valid pulse; first request accepted first cycle after rst low.

Verification
REQ-045 Refill 0x1FC0_0014, arready 1 cycle late, R beats 11,22,33,44 with rlast on 4th -> araddr 0x1FC0_0010, one ret_valid, ret_data 0x00000044_00000033_00000022_00000011.
REQ-046 Writeback 0x8000_0020 data 0xDDDD_CCCC_BBBB_AAAA pattern, wready toggling 1/0 -> wdata sequence words 0..3, wlast only with word 3, wr_valid once after bvalid.
REQ-047 wr_req 0x8000_0040 and rd_req 0x8000_004C same cycle -> write accepted, rd_rdy low until wr_valid; AR issued the cycle after W_IDLE return.
REQ-048 wr_req 0x8000_0040 and rd_req 0x8000_0080 same cycle -> both accepted same cycle, AR and AW both asserted next cycle.
REQ-049 rst asserted after 2nd R beat -> rready/arvalid 0 immediately, no ret_valid; new refill after release completes correctly with counter from 0.
REQ-050 rvalid with rlast on beat 2 (protocol violation) -> no ret_valid until 4th beat accepted.
